uio_port_arbiter: RTL and testbench

Shares the 8-bit bidirectional uio pin bank between two internal requesters.
- Each request is a single-beat transfer: either drive a byte onto the pins, or sample the pins.
- Owns uio_out and uio_oe. Inserts high-Z turnaround cycles whenever pin direction changes, so the chip and the external device never drive the pins at the same time.
- Sits between the top-level pin wrapper and the design's internal bus users.

---
 rtl/uio_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_uio_port_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uio_port_arbiter.sv
// Two-requester arbiter for the shared 8-bit uio pin bank.
// Single-beat reads/writes, round-robin grant, high-Z turnaround on every direction change.
module uio_port_arbiter #(
    parameter int unsigned TURNAROUND = 1,
    parameter logic [7:0]  OE_MASK    = 8'hFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [1:0] dir,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic [1:0] ack,
    output logic [7:0] rdata,
    output logic       busy,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TURN = 2'd1,
        XFER = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            gnt_q, gnt_d;
    logic            gdir_q, gdir_d;
    logic [DW-1:0]   gwdata_q, gwdata_d;
    logic            last_grant_q, last_grant_d;
    logic            bus_dir_q, bus_dir_d;
    logic [DW-1:0]   uio_out_q, uio_out_d;
    logic [DW-1:0]   uio_oe_q, uio_oe_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [1:0]      ack_q, ack_d;
    logic            busy_q, busy_d;

    logic [1:0]      elig;
    logic            sel;
    logic            sel_dir;
    logic [DW-1:0]   sel_wdata;

    // A request whose ack is still visible is not re-granted in that cycle.
    always_comb begin
        elig      = req & ~ack_q;
        sel       = (&elig) ? ~last_grant_q : elig[1];
        sel_dir   = dir[sel];
        sel_wdata = sel ? wdata1 : wdata0;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        gnt_d        = gnt_q;
        gdir_d       = gdir_q;
        gwdata_d     = gwdata_q;
        last_grant_d = last_grant_q;
        bus_dir_d    = bus_dir_q;
        uio_out_d    = uio_out_q;
        uio_oe_d     = uio_oe_q;
        rdata_d      = rdata_q;
        ack_d        = 2'b00;

        unique case (state_q)
            IDLE: begin
                if (|elig) begin
                    gnt_d        = sel;
                    gdir_d       = sel_dir;
                    gwdata_d     = sel_wdata;
                    last_grant_d = sel;
                    if (sel_dir == bus_dir_q) begin
                        state_d = XFER;
                        if (sel_dir) begin
                            uio_out_d = sel_wdata;
                            uio_oe_d  = OE_MASK;
                        end
                    end else begin
                        state_d   = TURN;
                        uio_oe_d  = '0;
                        cnt_d     = CW'(TURNAROUND - 1);
                        bus_dir_d = sel_dir;
                    end
                end
            end
            TURN: begin
                uio_oe_d = '0;
                if (cnt_q == '0) begin
                    state_d = XFER;
                    if (gdir_q) begin
                        uio_out_d = gwdata_q;
                        uio_oe_d  = OE_MASK;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            XFER: begin
                ack_d[gnt_q] = 1'b1;
                if (!gdir_q) begin
                    rdata_d = uio_in;
                end
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                uio_oe_d = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            gnt_q        <= 1'b0;
            gdir_q       <= 1'b0;
            gwdata_q     <= '0;
            last_grant_q <= 1'b1;
            bus_dir_q    <= 1'b0;
            uio_out_q    <= '0;
            uio_oe_q     <= '0;
            rdata_q      <= '0;
            ack_q        <= 2'b00;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            gnt_q        <= gnt_d;
            gdir_q       <= gdir_d;
            gwdata_q     <= gwdata_d;
            last_grant_q <= last_grant_d;
            bus_dir_q    <= bus_dir_d;
            uio_out_q    <= uio_out_d;
            uio_oe_q     <= uio_oe_d;
            rdata_q      <= rdata_d;
            ack_q        <= ack_d;
            busy_q       <= busy_d;
        end
    end

    assign ack     = ack_q;
    assign rdata   = rdata_q;
    assign busy    = busy_q;
    assign uio_out = uio_out_q;
    assign uio_oe  = uio_oe_q;

endmodule

// File: tb/tb_uio_port_arbiter.sv
// Bench for uio_port_arbiter: cycle vectors on two instances (default and TURNAROUND=3/OE_MASK=0F)
// checked through an expectation queue, plus a latency sequence and pin-safety monitor.
module tb_uio_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [1:0] req_a, dir_a, req_b, dir_b;
    logic [7:0] w0_a, w1_a, ui_a, w0_b, w1_b, ui_b;
    logic [1:0] ack_a, ack_b;
    logic [7:0] rd_a, rd_b, out_a, out_b, oe_a, oe_b;
    logic       busy_a, busy_b;

    uio_port_arbiter u_a (
        .clk(clk), .rst_n(rst_n), .req(req_a), .dir(dir_a),
        .wdata0(w0_a), .wdata1(w1_a), .ack(ack_a), .rdata(rd_a), .busy(busy_a),
        .uio_in(ui_a), .uio_out(out_a), .uio_oe(oe_a)
    );

    uio_port_arbiter #(.TURNAROUND(3), .OE_MASK(8'h0F)) u_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .dir(dir_b),
        .wdata0(w0_b), .wdata1(w1_b), .ack(ack_b), .rdata(rd_b), .busy(busy_b),
        .uio_in(ui_b), .uio_out(out_b), .uio_oe(oe_b)
    );

    typedef struct {
        bit         b;
        bit         r;
        logic [1:0] req;
        logic [1:0] dir;
        logic [7:0] w0;
        logic [7:0] w1;
        logic [7:0] ui;
        logic [1:0] ack;
        logic [7:0] oe;
        logic [7:0] out;
        logic [7:0] rd;
        logic       busy;
    } vec_t;

    typedef struct {
        logic [1:0] ack;
        logic [7:0] oe;
        logic [7:0] out;
        logic [7:0] rd;
        logic       busy;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;

    function automatic void add(bit b, bit r, logic [1:0] rq, logic [1:0] dr,
                                logic [7:0] w0, logic [7:0] w1, logic [7:0] ui,
                                logic [1:0] ak, logic [7:0] oe, logic [7:0] out,
                                logic [7:0] rd, logic bz);
        vec_t v;
        v.b = b; v.r = r; v.req = rq; v.dir = dr; v.w0 = w0; v.w1 = w1; v.ui = ui;
        v.ack = ak; v.oe = oe; v.out = out; v.rd = rd; v.busy = bz;
        tbl.push_back(v);
    endfunction

    task automatic drive(input vec_t v);
        rst_n = v.r;
        if (v.b) begin
            req_b = v.req; dir_b = v.dir; w0_b = v.w0; w1_b = v.w1; ui_b = v.ui;
            req_a = 2'b00;
        end else begin
            req_a = v.req; dir_a = v.dir; w0_a = v.w0; w1_a = v.w1; ui_a = v.ui;
            req_b = 2'b00;
        end
    endtask

    task automatic compare(input string name, input int idx, input bit b, input exp_t e);
        exp_t g;
        if (b) begin
            g.ack = ack_b; g.oe = oe_b; g.out = out_b; g.rd = rd_b; g.busy = busy_b;
        end else begin
            g.ack = ack_a; g.oe = oe_a; g.out = out_a; g.rd = rd_a; g.busy = busy_a;
        end
        n_vec++;
        if (g.ack !== e.ack || g.oe !== e.oe || g.out !== e.out || g.rd !== e.rd || g.busy !== e.busy) begin
            n_bad++;
            $display("FAIL %s[%0d] dut%s: got ack=%b oe=%h out=%h rdata=%h busy=%b, want ack=%b oe=%h out=%h rdata=%h busy=%b",
                     name, idx, b ? "B" : "A", g.ack, g.oe, g.out, g.rd, g.busy,
                     e.ack, e.oe, e.out, e.rd, e.busy);
        end
    endtask

    // Pin safety: never two acks at once, enables only all-off or the mask.
    always @(negedge clk) begin
        if (mon_en && rst_n === 1'b1) begin
            if (ack_a == 2'b11 || ack_b == 2'b11) begin
                n_bad++;
                $display("FAIL ack_onehot: got ackA=%b ackB=%b, want at most one bit", ack_a, ack_b);
            end
            if (oe_a != 8'h00 && oe_a != 8'hFF) begin
                n_bad++;
                $display("FAIL oe_legal_A: got %h, want 00 or FF", oe_a);
            end
            if (oe_b != 8'h00 && oe_b != 8'h0F) begin
                n_bad++;
                $display("FAIL oe_legal_B: got %h, want 00 or 0F", oe_b);
            end
        end
    end

    initial begin
        exp_t e;
        int   lat;
        bit   got;

        rst_n = 1'b0;
        req_a = '0; dir_a = '0; w0_a = '0; w1_a = '0; ui_a = '0;
        req_b = '0; dir_b = '0; w0_b = '0; w1_b = '0; ui_b = '0;

        // b r  req   dir   w0     w1     ui     ack   oe     out    rd     busy
        // reset, then idle
        add(0,0,2'b00,2'b00,8'h00,8'h00,8'h00, 2'b00,8'h00,8'h00,8'h00,0);
        add(0,0,2'b00,2'b00,8'h00,8'h00,8'h00, 2'b00,8'h00,8'h00,8'h00,0);
        add(0,1,2'b00,2'b00,8'h00,8'h00,8'h00, 2'b00,8'h00,8'h00,8'h00,0);
        // read, no turnaround
        add(0,1,2'b01,2'b00,8'h00,8'h00,8'h3C, 2'b00,8'h00,8'h00,8'h00,1);
        add(0,1,2'b00,2'b00,8'h00,8'h00,8'h3C, 2'b01,8'h00,8'h00,8'h3C,0);
        add(0,1,2'b00,2'b00,8'h00,8'h00,8'h00, 2'b00,8'h00,8'h00,8'h3C,0);
        // write with turnaround, req1 held for a second grant
        add(0,1,2'b10,2'b10,8'h00,8'hA5,8'h00, 2'b00,8'h00,8'h00,8'h3C,1);
        add(0,1,2'b10,2'b10,8'h00,8'hA5,8'h00, 2'b00,8'hFF,8'hA5,8'h3C,1);
        add(0,1,2'b10,2'b10,8'h00,8'hA5,8'h00, 2'b10,8'hFF,8'hA5,8'h3C,0);
        add(0,1,2'b10,2'b10,8'h00,8'hA5,8'h00, 2'b00,8'hFF,8'hA5,8'h3C,0);
        add(0,1,2'b10,2'b10,8'h00,8'hA5,8'h00, 2'b00,8'hFF,8'hA5,8'h3C,1);
        add(0,1,2'b00,2'b00,8'h00,8'h00,8'h00, 2'b10,8'hFF,8'hA5,8'h3C,0);
        add(0,1,2'b00,2'b00,8'h00,8'h00,8'h00, 2'b00,8'hFF,8'hA5,8'h3C,0);
        // contention, both writing: 0,1,0,1
        add(0,1,2'b11,2'b11,8'h11,8'h22,8'h00, 2'b00,8'hFF,8'h11,8'h3C,1);
        add(0,1,2'b11,2'b11,8'h11,8'h22,8'h00, 2'b01,8'hFF,8'h11,8'h3C,0);
        add(0,1,2'b11,2'b11,8'h11,8'h22,8'h00, 2'b00,8'hFF,8'h22,8'h3C,1);
        add(0,1,2'b11,2'b11,8'h11,8'h22,8'h00, 2'b10,8'hFF,8'h22,8'h3C,0);
        add(0,1,2'b11,2'b11,8'h11,8'h22,8'h00, 2'b00,8'hFF,8'h11,8'h3C,1);
        add(0,1,2'b11,2'b11,8'h11,8'h22,8'h00, 2'b01,8'hFF,8'h11,8'h3C,0);
        add(0,1,2'b11,2'b11,8'h11,8'h22,8'h00, 2'b00,8'hFF,8'h22,8'h3C,1);
        add(0,1,2'b00,2'b00,8'h00,8'h00,8'h00, 2'b10,8'hFF,8'h22,8'h3C,0);
        add(0,1,2'b00,2'b00,8'h00,8'h00,8'h00, 2'b00,8'hFF,8'h22,8'h3C,0);
        // instance B: write 5A with 3 turnaround cycles, then read C3
        add(1,1,2'b01,2'b01,8'h5A,8'h00,8'h00, 2'b00,8'h00,8'h00,8'h00,1);
        add(1,1,2'b00,2'b00,8'h00,8'h00,8'h00, 2'b00,8'h00,8'h00,8'h00,1);
        add(1,1,2'b00,2'b00,8'h00,8'h00,8'h00, 2'b00,8'h00,8'h00,8'h00,1);
        add(1,1,2'b00,2'b00,8'h00,8'h00,8'h00, 2'b00,8'h0F,8'h5A,8'h00,1);
        add(1,1,2'b00,2'b00,8'h00,8'h00,8'h00, 2'b01,8'h0F,8'h5A,8'h00,0);
        add(1,1,2'b00,2'b00,8'h00,8'h00,8'h00, 2'b00,8'h0F,8'h5A,8'h00,0);
        add(1,1,2'b01,2'b00,8'h00,8'h00,8'hC3, 2'b00,8'h00,8'h5A,8'h00,1);
        add(1,1,2'b00,2'b00,8'h00,8'h00,8'hC3, 2'b00,8'h00,8'h5A,8'h00,1);
        add(1,1,2'b00,2'b00,8'h00,8'h00,8'hC3, 2'b00,8'h00,8'h5A,8'h00,1);
        add(1,1,2'b00,2'b00,8'h00,8'h00,8'hC3, 2'b00,8'h00,8'h5A,8'h00,1);
        add(1,1,2'b00,2'b00,8'h00,8'h00,8'hC3, 2'b01,8'h00,8'h5A,8'hC3,0);
        add(1,1,2'b00,2'b00,8'h00,8'h00,8'h00, 2'b00,8'h00,8'h5A,8'hC3,0);
        // instance A: write-to-read turnaround, then reset during a write's TURN
        add(0,1,2'b01,2'b00,8'h00,8'h00,8'h66, 2'b00,8'h00,8'h22,8'h3C,1);
        add(0,1,2'b01,2'b00,8'h00,8'h00,8'h66, 2'b00,8'h00,8'h22,8'h3C,1);
        add(0,1,2'b00,2'b00,8'h00,8'h00,8'h66, 2'b01,8'h00,8'h22,8'h66,0);
        add(0,1,2'b00,2'b00,8'h00,8'h00,8'h00, 2'b00,8'h00,8'h22,8'h66,0);
        add(0,1,2'b10,2'b10,8'h00,8'h99,8'h00, 2'b00,8'h00,8'h22,8'h66,1);
        add(0,0,2'b00,2'b00,8'h00,8'h00,8'h00, 2'b00,8'h00,8'h00,8'h00,0);
        add(0,1,2'b01,2'b00,8'h00,8'h00,8'h5E, 2'b00,8'h00,8'h00,8'h00,1);
        add(0,1,2'b00,2'b00,8'h00,8'h00,8'h5E, 2'b01,8'h00,8'h00,8'h5E,0);
        add(0,1,2'b00,2'b00,8'h00,8'h00,8'h00, 2'b00,8'h00,8'h00,8'h5E,0);
        // opposite directions together: req1 write wins, req0 read follows after turnaround
        add(0,1,2'b11,2'b10,8'h00,8'hB4,8'h47, 2'b00,8'h00,8'h00,8'h5E,1);
        add(0,1,2'b11,2'b10,8'h00,8'hB4,8'h47, 2'b00,8'hFF,8'hB4,8'h5E,1);
        add(0,1,2'b11,2'b10,8'h00,8'hB4,8'h47, 2'b10,8'hFF,8'hB4,8'h5E,0);
        add(0,1,2'b11,2'b10,8'h00,8'hB4,8'h47, 2'b00,8'h00,8'hB4,8'h5E,1);
        add(0,1,2'b00,2'b00,8'h00,8'h00,8'h47, 2'b00,8'h00,8'hB4,8'h5E,1);
        add(0,1,2'b00,2'b00,8'h00,8'h00,8'h47, 2'b01,8'h00,8'hB4,8'h47,0);
        add(0,1,2'b00,2'b00,8'h00,8'h00,8'h00, 2'b00,8'h00,8'hB4,8'h47,0);

        foreach (tbl[i]) begin
            @(negedge clk);
            if (i == 2) mon_en = 1'b1;
            drive(tbl[i]);
            e.ack = tbl[i].ack; e.oe = tbl[i].oe; e.out = tbl[i].out;
            e.rd = tbl[i].rd; e.busy = tbl[i].busy;
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            compare("vec", i, tbl[i].b, e);
        end

        // B (fresh from reset, bus parked read): write E7 via req1, req and wdata dropped after capture
        @(negedge clk);
        req_b = 2'b10; dir_b = 2'b10; w1_b = 8'hE7;
        e.ack = 2'b10; e.oe = 8'h0F; e.out = 8'hE7; e.rd = 8'h00; e.busy = 1'b0;
        sb.push_back(e);
        lat = 0;
        got = 1'b0;
        for (int c = 1; c <= 20 && !got; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                req_b = 2'b00; w1_b = 8'h00;
            end
            if (ack_b != 2'b00) begin
                got = 1'b1;
                lat = c;
            end
        end
        n_vec++;
        if (!got || lat != 5) begin
            n_bad++;
            $display("FAIL wr_latency_B: got ack after %0d cycles (seen=%0b), want 5", lat, got);
        end
        e = sb.pop_front();
        compare("wr_ack_B", 0, 1'b1, e);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
